fft_mem_responder: RTL

Shared data-memory responder serving the FFT accelerator's memory-master port and the CPU load/store port. It holds the sample memory and arbitrates ownership: the CPU owns it by default, the accelerator owns it from its start pulse until its done pulse, and a watchdog reclaims it if done never arrives. The accelerator port has zero-latency combinational read so a master that samples data one cycle after driving an address works unmodified. The CPU port has registered one-cycle read latency.

---
 rtl/fft_mem_responder.sv | 101 ++++++++++
 1 files changed

// File: rtl/fft_mem_responder.sv
// Shared sample memory between the FFT accelerator and the CPU load/store port.
// Ownership is CPU by default, accelerator from start until done or watchdog expiry.
module fft_mem_responder #(
  parameter int DATA_W  = 19,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              acc_start,
  input  logic              acc_done,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic              acc_we,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              busy,
  output logic              acc_err
);

  typedef enum logic {CPU_OWN, ACC_OWN} state_t;

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t              state, state_next;
  logic [15:0]         watchdog, watchdog_next;
  logic                err_next;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                cpu_rd;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CPU_OWN;
      watchdog   <= '0;
      acc_err    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      state      <= state_next;
      watchdog   <= watchdog_next;
      acc_err    <= err_next;
      cpu_rvalid <= cpu_rd;
      if (cpu_rd) cpu_rdata <= mem[cpu_addr];
    end
  end

  // One write port shared by both masters; ownership decides whose write lands.
  always_comb begin
    state_next    = state;
    watchdog_next = watchdog;
    err_next      = acc_err;
    mem_we        = 1'b0;
    mem_waddr     = cpu_addr;
    mem_wdata     = cpu_wdata;
    cpu_rd        = 1'b0;
    cpu_stall     = 1'b0;
    case (state)
      CPU_OWN: begin
        watchdog_next = '0;
        mem_we        = cpu_req && cpu_we;
        cpu_rd        = cpu_req && !cpu_we;
        if (acc_we)    err_next   = 1'b1;
        if (acc_start) state_next = ACC_OWN;
      end
      ACC_OWN: begin
        cpu_stall     = cpu_req;
        watchdog_next = watchdog + 16'd1;
        if (acc_we) begin
          mem_we    = 1'b1;
          mem_waddr = acc_addr;
          mem_wdata = acc_wdata;
        end
        if (acc_done) begin
          state_next = CPU_OWN;
        end else if (watchdog == WD_LAST) begin
          state_next = CPU_OWN;
          err_next   = 1'b1;
        end
      end
    endcase
  end

  // Contents are deliberately not reset, but writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign acc_rdata = mem[acc_addr];
  assign busy      = (state == ACC_OWN);

endmodule
